// File: rtl/tube_responder_pkg.sv
// Shared constants for the Tube responder: register offsets, status bit
// positions and channel count.
package tube_responder_pkg;

    localparam int NCH = 4;

    // adr[0] selects the register within a channel
    localparam logic ST  = 1'b0;
    localparam logic DAT = 1'b1;

    // Status register bit positions
    localparam int RXA = 7;  // P2H FIFO has data for the host
    localparam int TXS = 6;  // H2P FIFO has room for the host
    localparam int OVF = 5;  // a host write was dropped on a full H2P FIFO
    localparam int IEN = 0;  // interrupt enable for this channel

    // Assemble a status byte from its flags; unused bits read as zero
    function automatic logic [7:0] status_byte(
        input logic rxa,
        input logic txs,
        input logic ovf,
        input logic ien
    );
        logic [7:0] s;
        s      = 8'h00;
        s[RXA] = rxa;
        s[TXS] = txs;
        s[OVF] = ovf;
        s[IEN] = ien;
        return s;
    endfunction

endpackage

// File: rtl/tube_fifo.sv
// Byte FIFO with one extra pointer bit so full and empty are distinguished
// without a separate count. A push to a full FIFO is accepted when a pop
// happens in the same cycle, because the pop frees the slot being written.
module tube_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic       clk,
    input  logic       reset_b,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] head,
    output logic       empty,
    output logic       full
);

    logic [7:0]  mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        push_ok;
    logic        pop_ok;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push_ok = push & (~full | pop);
    assign pop_ok  = pop & ~empty;
    assign head    = mem_q[rd_ptr_q[AW-1:0]];

    // Advance pointers for accepted operations
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Pointer registers
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/tube_responder.sv
// Tube responder: four host<->parasite byte channels behind a phi2-strobed
// register bus. Bus signals are sampled while phi2 is high and the access
// commits on the clk cycle that sees phi2 fall.
module tube_responder
    import tube_responder_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic       clk,
    input  logic       reset_b,
    input  logic       phi2,
    input  logic       cs_b,
    input  logic       rnw,
    input  logic [2:0] adr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       dout_oe,
    output logic       irq_b,
    input  logic [1:0] p_ch,
    input  logic       p_wr,
    input  logic [7:0] p_din,
    input  logic       p_rd,
    output logic [7:0] p_dout,
    output logic [3:0] p_h2p_avail,
    output logic [3:0] p_p2h_space
);

    // Captured bus cycle
    logic       phi2_q, phi2_d;
    logic       cs_b_q, cs_b_d;
    logic       rnw_q, rnw_d;
    logic [2:0] adr_q, adr_d;
    logic [7:0] din_q, din_d;

    logic [NCH-1:0] ien_q, ien_d;
    logic [NCH-1:0] ovf_q, ovf_d;
    logic           irq_b_q, irq_b_d;

    logic       commit;
    logic [1:0] cmt_ch;
    logic       cmt_dat;

    logic [NCH-1:0] h2p_push, h2p_pop, h2p_empty, h2p_full;
    logic [NCH-1:0] p2h_push, p2h_pop, p2h_empty, p2h_full;
    logic [7:0]     h2p_head [NCH];
    logic [7:0]     p2h_head [NCH];

    logic [1:0] rd_ch;

    // Sample the bus while phi2 is high; hold the sample once it drops
    always_comb begin
        phi2_d = phi2;
        cs_b_d = cs_b_q;
        rnw_d  = rnw_q;
        adr_d  = adr_q;
        din_d  = din_q;
        if (phi2) begin
            cs_b_d = cs_b;
            rnw_d  = rnw;
            adr_d  = adr;
            din_d  = din;
        end
    end

    assign commit  = phi2_q & ~phi2 & ~cs_b_q;
    assign cmt_ch  = adr_q[2:1];
    assign cmt_dat = (adr_q[0] == DAT);

    // Per-channel FIFO pairs and their push/pop requests
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        assign h2p_push[gi] = commit & ~rnw_q & cmt_dat & (cmt_ch == 2'(gi));
        assign h2p_pop[gi]  = p_rd & (p_ch == 2'(gi));
        assign p2h_push[gi] = p_wr & (p_ch == 2'(gi));
        assign p2h_pop[gi]  = commit & rnw_q & cmt_dat & (cmt_ch == 2'(gi));

        tube_fifo #(.DEPTH(DEPTH), .AW(AW)) u_h2p (
            .clk     (clk),
            .reset_b (reset_b),
            .push    (h2p_push[gi]),
            .din     (din_q),
            .pop     (h2p_pop[gi]),
            .head    (h2p_head[gi]),
            .empty   (h2p_empty[gi]),
            .full    (h2p_full[gi])
        );

        tube_fifo #(.DEPTH(DEPTH), .AW(AW)) u_p2h (
            .clk     (clk),
            .reset_b (reset_b),
            .push    (p2h_push[gi]),
            .din     (p_din),
            .pop     (p2h_pop[gi]),
            .head    (p2h_head[gi]),
            .empty   (p2h_empty[gi]),
            .full    (p2h_full[gi])
        );
    end

    // Status-register side effects, overflow tracking and interrupt level
    always_comb begin
        ien_d = ien_q;
        ovf_d = ovf_q;
        if (commit && !cmt_dat) begin
            if (rnw_q) ovf_d[cmt_ch] = 1'b0;
            else       ien_d[cmt_ch] = din_q[0];
        end
        for (int i = 0; i < NCH; i++) begin
            // a concurrent parasite pop makes room, so only a true drop counts
            if (h2p_push[i] && h2p_full[i] && !h2p_pop[i]) ovf_d[i] = 1'b1;
        end
        irq_b_d = ~|(ien_q & ~p2h_empty);
    end

    // State registers; reset also drops phi2_q so a pending commit is lost
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            phi2_q  <= 1'b0;
            cs_b_q  <= 1'b1;
            rnw_q   <= 1'b1;
            adr_q   <= '0;
            din_q   <= '0;
            ien_q   <= '0;
            ovf_q   <= '0;
            irq_b_q <= 1'b1;
        end else begin
            phi2_q  <= phi2_d;
            cs_b_q  <= cs_b_d;
            rnw_q   <= rnw_d;
            adr_q   <= adr_d;
            din_q   <= din_d;
            ien_q   <= ien_d;
            ovf_q   <= ovf_d;
            irq_b_q <= irq_b_d;
        end
    end

    assign rd_ch = adr[2:1];

    // Host read mux follows the live address, not the captured one
    always_comb begin
        dout = 8'h00;
        if (adr[0] == DAT) begin
            if (!p2h_empty[rd_ch]) dout = p2h_head[rd_ch];
        end else begin
            dout = status_byte(~p2h_empty[rd_ch], ~h2p_full[rd_ch],
                               ovf_q[rd_ch], ien_q[rd_ch]);
        end
    end

    assign dout_oe     = ~cs_b & rnw & phi2;
    assign irq_b       = irq_b_q;
    assign p_dout      = h2p_empty[p_ch] ? 8'h00 : h2p_head[p_ch];
    assign p_h2p_avail = ~h2p_empty;
    assign p_p2h_space = ~p2h_full;

endmodule

// File: tb/tb_tube_responder.sv
// Directed bench for tube_responder: each task drives one scenario and
// checks hand-computed expectations inline.
module tb_tube_responder;

    logic       clk = 1'b0;
    logic       reset_b = 1'b0;
    logic       phi2 = 1'b0;
    logic       cs_b = 1'b1;
    logic       rnw = 1'b1;
    logic [2:0] adr = 3'd0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       dout_oe;
    logic       irq_b;
    logic [1:0] p_ch = 2'd0;
    logic       p_wr = 1'b0;
    logic [7:0] p_din = 8'h00;
    logic       p_rd = 1'b0;
    logic [7:0] p_dout;
    logic [3:0] p_h2p_avail;
    logic [3:0] p_p2h_space;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tube_responder #(.DEPTH(4), .AW(2)) dut (
        .clk         (clk),
        .reset_b     (reset_b),
        .phi2        (phi2),
        .cs_b        (cs_b),
        .rnw         (rnw),
        .adr         (adr),
        .din         (din),
        .dout        (dout),
        .dout_oe     (dout_oe),
        .irq_b       (irq_b),
        .p_ch        (p_ch),
        .p_wr        (p_wr),
        .p_din       (p_din),
        .p_rd        (p_rd),
        .p_dout      (p_dout),
        .p_h2p_avail (p_h2p_avail),
        .p_p2h_space (p_p2h_space)
    );

    // One host bus cycle: two clocks of phi2 high, dout sampled just before
    // phi2 falls; returns on the negedge after the commit edge.
    task automatic bus_cycle(input logic r, input logic [2:0] a, input logic [7:0] d,
                             output logic [7:0] rd_val, output logic oe_val);
        @(negedge clk);
        cs_b = 1'b0; rnw = r; adr = a; din = d; phi2 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rd_val = dout;
        oe_val = dout_oe;
        phi2 = 1'b0;
        @(negedge clk);
        cs_b = 1'b1; rnw = 1'b1;
        $display("bus %s adr=%0d din=%02h dout=%02h", r ? "RD" : "WR", a, d, rd_val);
    endtask

    task automatic p_push(input logic [1:0] ch, input logic [7:0] d);
        @(negedge clk);
        p_ch = ch; p_din = d; p_wr = 1'b1;
        @(negedge clk);
        p_wr = 1'b0;
        $display("p_push ch=%0d data=%02h", ch, d);
    endtask

    task automatic p_pop(input logic [1:0] ch);
        @(negedge clk);
        p_ch = ch; p_rd = 1'b1;
        @(negedge clk);
        p_rd = 1'b0;
        $display("p_pop ch=%0d", ch);
    endtask

    task automatic test_reset;
        logic [7:0] v;
        logic oe;
        repeat (3) @(negedge clk);
        n_checks++;
        if (irq_b !== 1'b1 || dout_oe !== 1'b0) begin
            n_fail++; $display("FAIL reset_ctl irq_b=%b dout_oe=%b required 1/0", irq_b, dout_oe);
        end
        n_checks++;
        if (p_h2p_avail !== 4'h0 || p_p2h_space !== 4'hF || p_dout !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_par avail=%h space=%h p_dout=%02h required 0/F/00",
                     p_h2p_avail, p_p2h_space, p_dout);
        end
        reset_b = 1'b1;
        bus_cycle(1'b1, 3'd0, 8'h00, v, oe);
        n_checks++;
        if (v !== 8'h40) begin n_fail++; $display("FAIL reset_status got=%02h required=40", v); end
        n_checks++;
        if (oe !== 1'b1) begin n_fail++; $display("FAIL read_oe got=%b required=1", oe); end
        bus_cycle(1'b1, 3'd1, 8'h00, v, oe);
        n_checks++;
        if (v !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%02h required=00", v); end
        bus_cycle(1'b1, 3'd0, 8'h00, v, oe);
        n_checks++;
        if (v !== 8'h40 || irq_b !== 1'b1) begin
            n_fail++; $display("FAIL reset_nochange status=%02h irq_b=%b required 40/1", v, irq_b);
        end
    endtask

    task automatic test_h2p;
        logic [7:0] v;
        logic oe;
        bus_cycle(1'b0, 3'd3, 8'hA5, v, oe);
        bus_cycle(1'b0, 3'd3, 8'h3C, v, oe);
        p_ch = 2'd1;
        #1;
        n_checks++;
        if (p_h2p_avail !== 4'b0010 || p_dout !== 8'hA5) begin
            n_fail++; $display("FAIL h2p_first avail=%b p_dout=%02h required 0010/a5", p_h2p_avail, p_dout);
        end
        p_pop(2'd1);
        n_checks++;
        if (p_dout !== 8'h3C) begin n_fail++; $display("FAIL h2p_second got=%02h required=3c", p_dout); end
        p_pop(2'd1);
        n_checks++;
        if (p_h2p_avail[1] !== 1'b0) begin n_fail++; $display("FAIL h2p_drain avail=%b required=0", p_h2p_avail[1]); end
    endtask

    task automatic test_overflow;
        logic [7:0] v;
        logic oe;
        for (int i = 0; i < 5; i++) bus_cycle(1'b0, 3'd5, 8'h10 + 8'(i), v, oe);
        bus_cycle(1'b1, 3'd4, 8'h00, v, oe);
        n_checks++;
        if (v !== 8'h20) begin n_fail++; $display("FAIL ovf_status got=%02h required=20", v); end
        bus_cycle(1'b1, 3'd4, 8'h00, v, oe);
        n_checks++;
        if (v !== 8'h00) begin n_fail++; $display("FAIL ovf_clear got=%02h required=00", v); end
        for (int i = 0; i < 4; i++) begin
            p_ch = 2'd2;
            #1;
            n_checks++;
            if (p_dout !== 8'h10 + 8'(i)) begin
                n_fail++; $display("FAIL ovf_data[%0d] got=%02h required=%02h", i, p_dout, 8'h10 + 8'(i));
            end
            p_pop(2'd2);
        end
        n_checks++;
        if (p_h2p_avail[2] !== 1'b0) begin n_fail++; $display("FAIL ovf_drop avail=%b required=0", p_h2p_avail[2]); end
    endtask

    task automatic test_irq;
        logic [7:0] v;
        logic oe;
        bus_cycle(1'b0, 3'd6, 8'h01, v, oe);
        @(negedge clk);
        p_ch = 2'd3; p_din = 8'h77; p_wr = 1'b1;
        @(negedge clk);
        p_wr = 1'b0;
        n_checks++;
        if (irq_b !== 1'b1) begin n_fail++; $display("FAIL irq_lag got=%b required=1", irq_b); end
        @(negedge clk);
        n_checks++;
        if (irq_b !== 1'b0) begin n_fail++; $display("FAIL irq_assert got=%b required=0", irq_b); end
        bus_cycle(1'b1, 3'd7, 8'h00, v, oe);
        n_checks++;
        if (v !== 8'h77) begin n_fail++; $display("FAIL irq_data got=%02h required=77", v); end
        @(negedge clk);
        n_checks++;
        if (irq_b !== 1'b1) begin n_fail++; $display("FAIL irq_release got=%b required=1", irq_b); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] v;
        logic oe;
        logic [7:0] exp_bytes [4];
        exp_bytes[0] = 8'h02; exp_bytes[1] = 8'h03; exp_bytes[2] = 8'h11; exp_bytes[3] = 8'h22;
        p_push(2'd0, 8'h01);
        p_push(2'd0, 8'h02);
        p_push(2'd0, 8'h03);
        bus_cycle(1'b1, 3'd0, 8'h00, v, oe);
        n_checks++;
        if (v !== 8'hC0 || p_p2h_space[0] !== 1'b1) begin
            n_fail++; $display("FAIL b2b_fill status=%02h space=%b required c0/1", v, p_p2h_space[0]);
        end
        // host data read whose commit cycle coincides with a parasite push
        @(negedge clk);
        cs_b = 1'b0; rnw = 1'b1; adr = 3'd1; phi2 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        v = dout;
        phi2 = 1'b0;
        p_ch = 2'd0; p_din = 8'h11; p_wr = 1'b1;
        @(negedge clk);
        p_wr = 1'b0; cs_b = 1'b1;
        $display("bus RD adr=1 dout=%02h with p_push 11", v);
        n_checks++;
        if (v !== 8'h01) begin n_fail++; $display("FAIL b2b_oldhead got=%02h required=01", v); end
        n_checks++;
        if (p_p2h_space[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_count space=%b required=1", p_p2h_space[0]); end
        p_push(2'd0, 8'h22);
        n_checks++;
        if (p_p2h_space[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_full space=%b required=0", p_p2h_space[0]); end
        for (int i = 0; i < 4; i++) begin
            bus_cycle(1'b1, 3'd1, 8'h00, v, oe);
            n_checks++;
            if (v !== exp_bytes[i]) begin
                n_fail++; $display("FAIL b2b_byte[%0d] got=%02h required=%02h", i, v, exp_bytes[i]);
            end
        end
        bus_cycle(1'b1, 3'd0, 8'h00, v, oe);
        n_checks++;
        if (v !== 8'h40) begin n_fail++; $display("FAIL b2b_empty status=%02h required=40", v); end
    endtask

    task automatic test_reset_mid_cycle;
        logic [7:0] v;
        logic oe;
        bus_cycle(1'b0, 3'd0, 8'h01, v, oe);
        bus_cycle(1'b0, 3'd3, 8'h99, v, oe);
        bus_cycle(1'b1, 3'd0, 8'h00, v, oe);
        n_checks++;
        if (v !== 8'h41 || p_h2p_avail !== 4'b0010) begin
            n_fail++; $display("FAIL rst_pre status=%02h avail=%b required 41/0010", v, p_h2p_avail);
        end
        @(negedge clk);
        cs_b = 1'b0; rnw = 1'b0; adr = 3'd1; din = 8'hEE; phi2 = 1'b1;
        @(negedge clk);
        reset_b = 1'b0;
        @(negedge clk);
        phi2 = 1'b0;
        @(negedge clk);
        cs_b = 1'b1; rnw = 1'b1;
        reset_b = 1'b1;
        $display("reset pulsed during write adr=1 din=ee");
        @(negedge clk);
        n_checks++;
        if (p_h2p_avail !== 4'h0 || p_p2h_space !== 4'hF) begin
            n_fail++; $display("FAIL rst_fifos avail=%b space=%b required 0000/1111", p_h2p_avail, p_p2h_space);
        end
        p_ch = 2'd0;
        #1;
        n_checks++;
        if (p_dout !== 8'h00) begin n_fail++; $display("FAIL rst_nopush p_dout=%02h required=00", p_dout); end
        bus_cycle(1'b1, 3'd0, 8'h00, v, oe);
        n_checks++;
        if (v !== 8'h40 || irq_b !== 1'b1) begin
            n_fail++; $display("FAIL rst_ien status=%02h irq_b=%b required 40/1", v, irq_b);
        end
    endtask

    initial begin
        test_reset;
        test_h2p;
        test_overflow;
        test_irq;
        test_back_to_back;
        test_reset_mid_cycle;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
